// File: rtl/register_file_if.sv
// Register file port bundle: one write port and two independent read ports.
// The master side drives indices and write data; the slave returns read data.
interface register_file_if #(
   parameter int N = 32
);
   // Write semantics: wr_ena is sampled on the rising clock together with
   // wr_addr/wr_data; there is no ready, and a write is always accepted
   // unless it targets x0 or reset is asserted.
   logic         wr_ena;
   logic [4:0]   wr_addr;
   logic [N-1:0] wr_data;
   logic [4:0]   rd_addr0;
   logic [N-1:0] rd_data0;
   logic [4:0]   rd_addr1;
   logic [N-1:0] rd_data1;

   modport master (
      output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
      input  rd_data0, rd_data1
   );

   modport slave (
      input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
      output rd_data0, rd_data1
   );
endinterface

// File: rtl/register_file.sv
// 32 x N architectural register file: one synchronous write port, two
// combinational read ports, x0 hard-wired to zero, optional write-through.
module register_file #(
   parameter int N      = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   register_file_if.slave  rf
);

   logic [N-1:0] regs [1:31];
   logic [N-1:0] word [0:31];
   logic [31:0]  wr_sel;
   logic         wr_live;
   logic         hit0;
   logic         hit1;

   // One-hot write decode; x0 never gets a select line.
   always_comb begin
      wr_sel  = '0;
      wr_live = rf.wr_ena && (rf.wr_addr != 5'd0);
      if (wr_live) begin
         wr_sel[rf.wr_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= rf.wr_data;
            end
         end
      end
   end

   // Mux32 source vector: slot 0 is a constant, not storage.
   always_comb begin
      word[0] = '0;
      for (int i = 1; i < 32; i++) begin
         word[i] = regs[i];
      end
   end

   always_comb begin
      hit0 = BYPASS && wr_live && (rf.rd_addr0 == rf.wr_addr);
      hit1 = BYPASS && wr_live && (rf.rd_addr1 == rf.wr_addr);
   end

   // Outputs are forced to zero while reset is held so a bypassed write
   // that will be dropped never appears on a read port.
   always_comb begin
      rf.rd_data0 = '0;
      rf.rd_data1 = '0;
      if (rst_n) begin
         rf.rd_data0 = hit0 ? rf.wr_data : word[rf.rd_addr0];
         rf.rd_data1 = hit1 ? rf.wr_data : word[rf.rd_addr1];
      end
   end

   a_wr_ena_known: assert property (
      @(posedge clk) disable iff (!rst_n) !$isunknown(rf.wr_ena)
   );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a write-through and a plain instance share one
// stimulus stream and are checked each cycle against an array model.
module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic        wr_ena;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr0;
   logic [4:0]  rd_addr1;

   logic [31:0] mem [32];
   logic [31:0] exp_q [$];
   int          n_cmp;
   int          n_err;
   bit          chk_en;

   register_file_if #(.N(32)) b_if ();
   register_file_if #(.N(32)) n_if ();

   assign b_if.wr_ena   = wr_ena;
   assign b_if.wr_addr  = wr_addr;
   assign b_if.wr_data  = wr_data;
   assign b_if.rd_addr0 = rd_addr0;
   assign b_if.rd_addr1 = rd_addr1;
   assign n_if.wr_ena   = wr_ena;
   assign n_if.wr_addr  = wr_addr;
   assign n_if.wr_data  = wr_data;
   assign n_if.rd_addr0 = rd_addr0;
   assign n_if.rd_addr1 = rd_addr1;

   register_file #(.N(32), .BYPASS(1'b1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (b_if.slave)
   );

   register_file #(.N(32), .BYPASS(1'b0)) dut_n (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (n_if.slave)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // behavioural model: plain array of 32 words, slot 0 never written
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      end else if (wr_ena && wr_addr != 5'd0) begin
         mem[wr_addr] <= wr_data;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (!rst_n) return 32'h0;
      if (a == 5'd0) return 32'h0;
      if (byp && wr_ena && wr_addr != 5'd0 && a == wr_addr) return wr_data;
      return mem[a];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_b_rd0", b_if.rd_data0, exp_rd(rd_addr0, 1'b1));
         check("cyc_b_rd1", b_if.rd_data1, exp_rd(rd_addr1, 1'b1));
         check("cyc_n_rd0", n_if.rd_data0, exp_rd(rd_addr0, 1'b0));
         check("cyc_n_rd1", n_if.rd_data1, exp_rd(rd_addr1, 1'b0));
      end
   end

   // driver tasks: called just after a rising edge, return just after the next
   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      wr_ena  = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk); #1;
      wr_ena  = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      chk_en   = 1'b0;
      rst_n    = 1'b0;
      wr_ena   = 1'b0;
      wr_addr  = 5'd0;
      wr_data  = 32'h0;
      rd_addr0 = 5'd1;
      rd_addr1 = 5'd31;
      #1;
      check("rst_b_rd0", b_if.rd_data0, 32'h0);
      check("rst_n_rd1", n_if.rd_data1, 32'h0);
      chk_en = 1'b1;
      idle();
      idle();
      rst_n = 1'b1;
      idle();

      // 1: asynchronous reset clears storage mid-cycle
      do_write(5'd5, 32'hDEADBEEF);
      rd_addr0 = 5'd5;
      #1;
      check("t1_before_b", b_if.rd_data0, 32'hDEADBEEF);
      check("t1_before_n", n_if.rd_data0, 32'hDEADBEEF);
      check("t1_model_x5", mem[5], 32'hDEADBEEF);
      #1 rst_n = 1'b0;
      #1;
      check("t1_async_b", b_if.rd_data0, 32'h0);
      check("t1_async_n", n_if.rd_data0, 32'h0);
      check("t1_model_clr", mem[5], 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      check("t1_after_b", b_if.rd_data0, 32'h0);

      // 3: sweep writes, then read pairs (i, 31-i)
      for (int i = 1; i < 32; i++) do_write(5'(i), i * 32'h01010101);
      check("t3_model_x31", mem[31], 32'h1F1F1F1F);
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back((i == 0) ? 32'h0 : i * 32'h01010101);
         exp_q.push_back((i == 31) ? 32'h0 : (31 - i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         logic [31:0] e0, e1;
         rd_addr0 = 5'(i);
         rd_addr1 = 5'(31 - i);
         #1;
         e0 = exp_q.pop_front();
         e1 = exp_q.pop_front();
         check("t3_b_rd0", b_if.rd_data0, e0);
         check("t3_b_rd1", b_if.rd_data1, e1);
         check("t3_n_rd0", n_if.rd_data0, e0);
         check("t3_n_rd1", n_if.rd_data1, e1);
      end
      idle();

      // 2: writes to x0 are discarded, even through the bypass path
      rd_addr0 = 5'd0;
      rd_addr1 = 5'd0;
      wr_ena   = 1'b1;
      wr_addr  = 5'd0;
      wr_data  = 32'hFFFFFFFF;
      #1;
      check("t2_byp_rd0", b_if.rd_data0, 32'h0);
      check("t2_byp_rd1", b_if.rd_data1, 32'h0);
      @(posedge clk); #1;
      wr_ena = 1'b0;
      check("t2_x0_b", b_if.rd_data0, 32'h0);
      check("t2_x0_n", n_if.rd_data1, 32'h0);
      for (int i = 1; i < 32; i++) begin
         rd_addr0 = 5'(i);
         #1;
         check("t2_keep_b", b_if.rd_data0, i * 32'h01010101);
      end
      idle();

      // 4: same-cycle write/read of x7
      do_write(5'd7, 32'h11);
      rd_addr0 = 5'd7;
      wr_ena   = 1'b1;
      wr_addr  = 5'd7;
      wr_data  = 32'h22;
      #1;
      check("t4_byp_new", b_if.rd_data0, 32'h22);
      check("t4_nobyp_old", n_if.rd_data0, 32'h11);
      @(posedge clk); #1;
      wr_ena = 1'b0;
      check("t4_byp_after", b_if.rd_data0, 32'h22);
      check("t4_nobyp_after", n_if.rd_data0, 32'h22);
      check("t4_model_x7", mem[7], 32'h22);

      // back-to-back writes: last one wins
      do_write(5'd9, 32'h1234);
      do_write(5'd9, 32'h5678);
      rd_addr1 = 5'd9;
      #1;
      check("b2b_n", n_if.rd_data1, 32'h5678);

      // 5: wr_ena low holds x3
      rd_addr1 = 5'd3;
      wr_ena   = 1'b0;
      wr_addr  = 5'd3;
      wr_data  = 32'hABCD;
      repeat (10) begin
         idle();
         check("t5_hold_b", b_if.rd_data1, 32'h03030303);
         check("t5_hold_n", n_if.rd_data1, 32'h03030303);
      end

      // 6: random traffic with occasional reset pulses
      for (int c = 0; c < 10000; c++) begin
         wr_ena   = 1'($urandom_range(0, 1));
         wr_addr  = 5'($urandom_range(0, 31));
         wr_data  = $urandom;
         rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rd_addr1 = 5'($urandom_range(0, 31));
         rst_n    = ($urandom_range(0, 199) != 0);
         idle();
      end
      rst_n  = 1'b1;
      wr_ena = 1'b0;
      idle();
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
